// File: rtl/hex_word_pager.sv
// Holds a captured debug word and shows one page of hex nibbles at a time to the
// 7-segment decoders. Pages advance on a debounced button press and on an optional timer.
module hex_word_pager #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_PERIOD     = 0,
  parameter int LZ_BLANK        = 0,
  localparam int PAGE_BITS      = 4 * NUM_DIGITS,
  localparam int PAGES          = DATA_WIDTH / PAGE_BITS,
  localparam int PAGE_W         = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  page_btn,
  output logic [PAGE_BITS-1:0]  nibbles,
  output logic [PAGE_W-1:0]     page_idx,
  output logic [NUM_DIGITS-1:0] blank,
  output logic                  valid
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'((AUTO_PERIOD == 0) ? 0 : AUTO_PERIOD - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } btn_state_t;

  logic [DATA_WIDTH-1:0] r_word;
  logic [PAGE_W-1:0]     r_page_idx;
  logic                  r_valid;
  logic [1:0]            r_sync;
  logic [1:0]            r_primed;
  logic                  r_armed;
  btn_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [AUTO_W-1:0]     r_auto_cnt;

  logic                  w_sync_btn;
  logic                  w_btn_adv;
  logic                  w_auto_adv;
  logic                  w_adv;
  logic [PAGE_W-1:0]     w_next_page;
  logic [PAGE_BITS-1:0]  w_nibbles;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_zero_above;

  assign w_sync_btn  = r_sync[1];
  assign w_btn_adv   = (r_state == S_PRESS_WAIT) && !w_sync_btn && (r_cnt == CNT_LAST) && r_armed;
  assign w_auto_adv  = (AUTO_PERIOD != 0) && (r_auto_cnt == AUTO_LAST);
  assign w_adv       = w_btn_adv || w_auto_adv;
  assign w_next_page = (r_page_idx == PAGE_LAST) ? '0 : r_page_idx + PAGE_W'(1);

  // NOTE: every register here uses <= so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync   <= 2'b11;
      r_primed <= 2'b00;
    end else begin
      r_sync   <= {r_sync[0], page_btn};
      r_primed <= {r_primed[0], 1'b1};
    end
  end

  // Presses only count once a real released level has been seen after reset, so a
  // button held through reset cannot produce an advance until it is pressed again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_armed <= 1'b0;
    end else if (r_primed[1] && w_sync_btn && (r_state == S_RELEASED)) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RELEASED;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_RELEASED: begin
          if (!w_sync_btn) begin
            r_state <= S_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (w_sync_btn)              r_state <= S_RELEASED;
          else if (r_cnt == CNT_LAST)  r_state <= S_PRESSED;
          else                         r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_PRESSED: begin
          if (w_sync_btn) begin
            r_state <= S_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (!w_sync_btn)             r_state <= S_PRESSED;
          else if (r_cnt == CNT_LAST)  r_state <= S_RELEASED;
          else                         r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: r_state <= S_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_auto_cnt <= '0;
    end else if ((AUTO_PERIOD == 0) || load_en || w_btn_adv || w_auto_adv) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
    end
  end

  // A load in the same cycle as any advance wins and returns to the first page.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word     <= '0;
      r_page_idx <= '0;
      r_valid    <= 1'b0;
    end else if (load_en) begin
      r_word     <= data_in;
      r_page_idx <= '0;
      r_valid    <= 1'b1;
    end else if (w_adv) begin
      r_page_idx <= w_next_page;
    end
  end

  assign w_nibbles = r_word[r_page_idx * PAGE_BITS +: PAGE_BITS];

  // NOTE: both outputs get a default first so no path through this block can infer a latch.
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    if (!r_valid) begin
      w_blank = '1;
    end else if (LZ_BLANK != 0) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        w_zero_above = w_zero_above && (w_nibbles[4*k +: 4] == 4'h0);
        w_blank[k]   = w_zero_above;
      end
    end
  end

  assign nibbles  = w_nibbles;
  assign page_idx = r_page_idx;
  assign blank    = w_blank;
  assign valid    = r_valid;

endmodule

// File: tb/tb_hex_word_pager.sv
// Directed bench for hex_word_pager: one instance for button paging with leading-zero
// blanking, a second instance for timer-driven paging.
module tb_hex_word_pager;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [31:0] data_in;
  logic        page_btn;
  logic [15:0] nibbles;
  logic [0:0]  page_idx;
  logic [3:0]  blank;
  logic        valid;

  logic        a_load;
  logic [31:0] a_data;
  logic        a_btn;
  logic [15:0] a_nibbles;
  logic [0:0]  a_page_idx;
  logic [3:0]  a_blank;
  logic        a_valid;

  int n_vec  = 0;
  int n_fail = 0;

  hex_word_pager #(
    .DATA_WIDTH(32), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(0), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .data_in(data_in), .page_btn(page_btn),
    .nibbles(nibbles), .page_idx(page_idx), .blank(blank), .valid(valid)
  );

  hex_word_pager #(
    .DATA_WIDTH(32), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(5), .LZ_BLANK(0)
  ) dut_auto (
    .clk(clk), .rst(rst), .load_en(a_load), .data_in(a_data), .page_btn(a_btn),
    .nibbles(a_nibbles), .page_idx(a_page_idx), .blank(a_blank), .valid(a_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [15:0] e_nib, input logic e_pg,
                            input logic [3:0] e_blk, input logic e_vld);
    check({tag, ".nibbles"}, 32'(nibbles), 32'(e_nib));
    check({tag, ".page_idx"}, 32'(page_idx), 32'(e_pg));
    check({tag, ".blank"}, 32'(blank), 32'(e_blk));
    check({tag, ".valid"}, 32'(valid), 32'(e_vld));
  endtask

  initial begin
    rst = 1'b0; load_en = 1'b0; data_in = '0; page_btn = 1'b1;
    a_load = 1'b0; a_data = '0; a_btn = 1'b1;

    // Reset state.
    tick(2);
    check_main("reset", 16'h0000, 1'b0, 4'hF, 1'b0);
    check("auto_reset.valid", 32'(a_valid), 32'd0);
    check("auto_reset.blank", 32'(a_blank), 32'hF);
    rst = 1'b1;
    tick(3);
    check("post_reset.valid", 32'(valid), 32'd0);

    // First load.
    load_en = 1'b1; data_in = 32'hDEADBEEF;
    tick();
    load_en = 1'b0;
    check_main("load", 16'hBEEF, 1'b0, 4'h0, 1'b1);

    // Press latency: page changes exactly at edge 7, then holds.
    page_btn = 1'b0;
    tick(6);
    check("press_edge6.page_idx", 32'(page_idx), 32'd0);
    tick();
    check_main("press_edge7", 16'hDEAD, 1'b1, 4'h0, 1'b1);
    tick(13);
    check("held.page_idx", 32'(page_idx), 32'd1);
    page_btn = 1'b1;
    tick(10);
    check("released.page_idx", 32'(page_idx), 32'd1);

    // Second press wraps back to page 0.
    page_btn = 1'b0;
    tick(6);
    check("wrap_edge6.page_idx", 32'(page_idx), 32'd1);
    tick();
    check_main("wrap_edge7", 16'hBEEF, 1'b0, 4'h0, 1'b1);
    page_btn = 1'b1;
    tick(10);

    // Short glitch is rejected.
    page_btn = 1'b0;
    tick(3);
    page_btn = 1'b1;
    tick(10);
    check("glitch.page_idx", 32'(page_idx), 32'd0);

    // Bouncy press then bouncy release: exactly one advance.
    for (int i = 0; i < 4; i++) begin
      page_btn = i[0];
      tick();
    end
    page_btn = 1'b0;
    tick(12);
    check("bounce_press.page_idx", 32'(page_idx), 32'd1);
    for (int i = 0; i < 4; i++) begin
      page_btn = ~i[0];
      tick();
    end
    page_btn = 1'b1;
    tick(10);
    check("bounce_release.page_idx", 32'(page_idx), 32'd1);

    // Clean press back to page 0.
    page_btn = 1'b0;
    tick(7);
    check("back_to_0.page_idx", 32'(page_idx), 32'd0);
    page_btn = 1'b1;
    tick(10);

    // Load coincides with a debounce advance from page 0: load wins.
    page_btn = 1'b0;
    tick(6);
    load_en = 1'b1; data_in = 32'h00000012;
    tick();
    load_en = 1'b0;
    check_main("collision", 16'h0012, 1'b0, 4'b1100, 1'b1);
    page_btn = 1'b1;
    tick(10);
    check("collision_after.page_idx", 32'(page_idx), 32'd0);

    // Upper page of 0x00000012 is all zero: every digit but digit 0 blanks.
    page_btn = 1'b0;
    tick(7);
    check_main("zero_page", 16'h0000, 1'b1, 4'b1110, 1'b1);
    page_btn = 1'b1;
    tick(10);

    // Reset while in PRESS_WAIT on page 1, button kept held through and after reset.
    page_btn = 1'b0;
    tick(4);
    check("pre_reset.page_idx", 32'(page_idx), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_main("mid_reset", 16'h0000, 1'b0, 4'hF, 1'b0);
    tick(20);
    check("held_after_reset.page_idx", 32'(page_idx), 32'd0);
    load_en = 1'b1; data_in = 32'h12345678;
    tick();
    load_en = 1'b0;
    check_main("reload", 16'h5678, 1'b0, 4'h0, 1'b1);
    page_btn = 1'b1;
    tick(10);
    check("release_after_reset.page_idx", 32'(page_idx), 32'd0);
    page_btn = 1'b0;
    tick(6);
    check("repress_edge6.page_idx", 32'(page_idx), 32'd0);
    tick();
    check_main("repress_edge7", 16'h1234, 1'b1, 4'h0, 1'b1);
    page_btn = 1'b1;
    tick(10);

    // Auto-advance every 5 cycles; mid-period load restarts the count.
    a_load = 1'b1; a_data = 32'h000A0005;
    tick();
    a_load = 1'b0;
    check("auto_load.nibbles", 32'(a_nibbles), 32'h0005);
    check("auto_load.page_idx", 32'(a_page_idx), 32'd0);
    check("auto_load.blank", 32'(a_blank), 32'h0);
    check("auto_load.valid", 32'(a_valid), 32'd1);
    tick(4);
    check("auto_c4.page_idx", 32'(a_page_idx), 32'd0);
    tick();
    check("auto_c5.page_idx", 32'(a_page_idx), 32'd1);
    check("auto_c5.nibbles", 32'(a_nibbles), 32'h000A);
    tick(4);
    check("auto_c9.page_idx", 32'(a_page_idx), 32'd1);
    tick();
    check("auto_c10.page_idx", 32'(a_page_idx), 32'd0);
    tick(2);
    a_load = 1'b1; a_data = 32'h11112222;
    tick();
    a_load = 1'b0;
    check("auto_reload.nibbles", 32'(a_nibbles), 32'h2222);
    tick(4);
    check("auto_restart4.page_idx", 32'(a_page_idx), 32'd0);
    tick();
    check("auto_restart5.page_idx", 32'(a_page_idx), 32'd1);
    check("auto_restart5.nibbles", 32'(a_nibbles), 32'h1111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
